// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the RR-side hazard tracker: stage-entry field widths,
// event counter width and the saturating counter helper.
package pipe_hazard_pkg;

    localparam int PIPE_DATA_W = 16;
    localparam int PIPE_RA_W   = 3;
    localparam int CNT_W       = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One tracked pipeline stage: registers the entry handed over by its predecessor
// (dropped when that entry is killed) and merges this cycle's result into it.
module pipe_stage_reg
    import pipe_hazard_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int RA_W   = PIPE_RA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic              ld_kill,
    input  logic              ld_wr_en,
    input  logic [RA_W-1:0]   ld_dest,
    input  logic              ld_rdy,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              res_we,
    input  logic [DATA_W-1:0] res_data,
    output logic              valid,
    output logic              wr_en,
    output logic [RA_W-1:0]   dest,
    output logic              rdy_eff,
    output logic [DATA_W-1:0] data_eff
);

    logic              rdy_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            wr_en  <= 1'b0;
            dest   <= '0;
            rdy_q  <= 1'b0;
            data_q <= '0;
        end else begin
            valid  <= ld_valid & ~ld_kill;
            wr_en  <= ld_wr_en;
            dest   <= ld_dest;
            rdy_q  <= ld_rdy;
            data_q <= ld_data;
        end
    end

    // A result written this cycle is visible immediately to forwarding and to the successor.
    assign rdy_eff  = rdy_q | res_we;
    assign data_eff = res_we ? res_data : data_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Tracks in-flight register writers after RR, forwards ready results to RR sources,
// stalls RR on an unready producer, applies partial flushes and reports retirement.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int RA_W   = PIPE_RA_W,
    parameter int NSRC   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_wr_en,
    input  logic [RA_W-1:0]              in_dest,
    input  logic [DEPTH-1:0]             res_we,
    input  logic [DEPTH*DATA_W-1:0]      res_data,
    input  logic [NSRC*RA_W-1:0]         src_addr,
    input  logic [NSRC-1:0]              src_used,
    input  logic                         flush,
    input  logic [$clog2(DEPTH+1)-1:0]   flush_k,
    output logic [NSRC-1:0]              fwd_en,
    output logic [NSRC*DATA_W-1:0]       fwd_data,
    output logic                         stall,
    output logic                         wb_valid,
    output logic [RA_W-1:0]              wb_dest,
    output logic [DATA_W-1:0]            wb_data,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt,
    output logic                         err_noresult
);

    localparam int FK_W = $clog2(DEPTH+1);
    localparam int LAST = DEPTH - 1;

    logic [DEPTH-1:0]  st_valid;
    logic [DEPTH-1:0]  st_wr;
    logic [DEPTH-1:0]  st_rdy;
    logic [RA_W-1:0]   st_dest [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];

    logic [DEPTH-1:0]  ld_valid;
    logic [DEPTH-1:0]  ld_kill;
    logic [DEPTH-1:0]  ld_wr;
    logic [DEPTH-1:0]  ld_rdy;
    logic [RA_W-1:0]   ld_dest [DEPTH];
    logic [DATA_W-1:0] ld_data [DEPTH];

    logic                   hazard;
    logic                   found;
    logic [NSRC-1:0]        fwd_en_c;
    logic [NSRC*DATA_W-1:0] fwd_data_c;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            // flush always kills the instruction trying to leave RR.
            assign ld_valid[g] = in_valid & ~stall;
            assign ld_kill[g]  = flush;
            assign ld_wr[g]    = in_wr_en;
            assign ld_dest[g]  = in_dest;
            assign ld_rdy[g]   = 1'b0;
            assign ld_data[g]  = '0;
        end else begin : g_body
            // Stage g-1 is killed when it lies within the flush_k youngest stages.
            assign ld_valid[g] = st_valid[g-1];
            assign ld_kill[g]  = flush & (flush_k >= FK_W'(g));
            assign ld_wr[g]    = st_wr[g-1];
            assign ld_dest[g]  = st_dest[g-1];
            assign ld_rdy[g]   = st_rdy[g-1];
            assign ld_data[g]  = st_data[g-1];
        end

        pipe_stage_reg #(
            .DATA_W (DATA_W),
            .RA_W   (RA_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .ld_valid (ld_valid[g]),
            .ld_kill  (ld_kill[g]),
            .ld_wr_en (ld_wr[g]),
            .ld_dest  (ld_dest[g]),
            .ld_rdy   (ld_rdy[g]),
            .ld_data  (ld_data[g]),
            .res_we   (res_we[g]),
            .res_data (res_data[g*DATA_W +: DATA_W]),
            .valid    (st_valid[g]),
            .wr_en    (st_wr[g]),
            .dest     (st_dest[g]),
            .rdy_eff  (st_rdy[g]),
            .data_eff (st_data[g])
        );
    end

    // The youngest matching writer is the architecturally newest value of the register.
    always_comb begin
        hazard     = 1'b0;
        found      = 1'b0;
        fwd_en_c   = '0;
        fwd_data_c = '0;
        for (int s = 0; s < NSRC; s++) begin
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && src_used[s] && st_valid[k] && st_wr[k] &&
                    (st_dest[k] == src_addr[s*RA_W +: RA_W])) begin
                    found = 1'b1;
                    if (st_rdy[k]) begin
                        fwd_en_c[s]                      = 1'b1;
                        fwd_data_c[s*DATA_W +: DATA_W]   = st_data[k];
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign fwd_en   = rst ? '0 : fwd_en_c;
    assign fwd_data = fwd_data_c;
    assign stall    = hazard & ~flush & ~rst;

    assign wb_valid = ~rst & st_valid[LAST] & st_wr[LAST] & st_rdy[LAST];
    assign wb_dest  = st_dest[LAST];
    assign wb_data  = wb_valid ? st_data[LAST] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            err_noresult <= 1'b0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, stall);
            flush_cnt <= sat_inc(flush_cnt, flush);
            if (st_valid[LAST] && st_wr[LAST] && !st_rdy[LAST]) begin
                err_noresult <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a stage-array reference model.
module tb_pipe_hazard_ctrl;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int RA_W   = 3;
    localparam int NSRC   = 2;
    localparam int FK_W   = 3;
    localparam int L      = DEPTH - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_wr_en;
    logic [RA_W-1:0]            in_dest;
    logic [DEPTH-1:0]           res_we;
    logic [DEPTH*DATA_W-1:0]    res_data;
    logic [NSRC*RA_W-1:0]       src_addr;
    logic [NSRC-1:0]            src_used;
    logic                       flush;
    logic [FK_W-1:0]            flush_k;
    logic [NSRC-1:0]            fwd_en;
    logic [NSRC*DATA_W-1:0]     fwd_data;
    logic                       stall;
    logic                       wb_valid;
    logic [RA_W-1:0]            wb_dest;
    logic [DATA_W-1:0]          wb_data;
    logic [15:0]                stall_cnt;
    logic [15:0]                flush_cnt;
    logic                       err_noresult;

    pipe_hazard_ctrl #(
        .DEPTH (DEPTH), .DATA_W (DATA_W), .RA_W (RA_W), .NSRC (NSRC)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_wr_en (in_wr_en),
        .in_dest (in_dest), .res_we (res_we), .res_data (res_data),
        .src_addr (src_addr), .src_used (src_used), .flush (flush), .flush_k (flush_k),
        .fwd_en (fwd_en), .fwd_data (fwd_data), .stall (stall),
        .wb_valid (wb_valid), .wb_dest (wb_dest), .wb_data (wb_data),
        .stall_cnt (stall_cnt), .flush_cnt (flush_cnt), .err_noresult (err_noresult)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what each tracked stage holds, oldest at index DEPTH-1.
    logic              m_valid [DEPTH];
    logic              m_wr    [DEPTH];
    logic [RA_W-1:0]   m_dest  [DEPTH];
    logic              m_rdy   [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    logic              m_err;
    int                m_scnt;
    int                m_fcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_valid[k] = 1'b0; m_wr[k] = 1'b0; m_dest[k] = '0; m_rdy[k] = 1'b0; m_data[k] = '0;
        end
        m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic clr_in();
        in_valid = 1'b0; in_wr_en = 1'b0; in_dest = '0; res_we = '0; res_data = '0;
        src_addr = '0; src_used = '0; flush = 1'b0; flush_k = '0;
    endtask

    function automatic int youngest_writer(input logic [RA_W-1:0] a);
        for (int k = 0; k < DEPTH; k++)
            if (m_valid[k] && m_wr[k] && m_dest[k] == a) return k;
        return -1;
    endfunction

    // Called at a falling edge with inputs already driven; checks, clocks, advances the model.
    task automatic step();
        logic [NSRC-1:0]        e_fen;
        logic [NSRC*DATA_W-1:0] e_fd;
        logic                   e_stall, e_wbv;
        logic [DATA_W-1:0]      e_wbd;
        logic                   r_eff [DEPTH];
        logic [DATA_W-1:0]      d_eff [DEPTH];
        int                     p;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            r_eff[k] = m_rdy[k] | res_we[k];
            d_eff[k] = res_we[k] ? res_data[k*DATA_W +: DATA_W] : m_data[k];
        end
        e_fen = '0; e_fd = '0; e_stall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (src_used[s]) begin
                p = youngest_writer(src_addr[s*RA_W +: RA_W]);
                if (p >= 0) begin
                    if (r_eff[p]) begin
                        e_fen[s] = 1'b1;
                        e_fd[s*DATA_W +: DATA_W] = d_eff[p];
                    end else begin
                        e_stall = 1'b1;
                    end
                end
            end
        end
        if (flush) e_stall = 1'b0;
        e_wbv = m_valid[L] && m_wr[L] && r_eff[L];
        e_wbd = e_wbv ? d_eff[L] : '0;

        chk("fwd_en", fwd_en, e_fen);
        chk("fwd_data", fwd_data & {{DATA_W{e_fen[1]}}, {DATA_W{e_fen[0]}}}, e_fd);
        chk("stall", stall, e_stall);
        chk("wb_valid", wb_valid, e_wbv);
        chk("wb_data", wb_data, e_wbd);
        if (e_wbv) chk("wb_dest", wb_dest, m_dest[L]);
        chk("err_noresult", err_noresult, m_err);
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("flush_cnt", flush_cnt, m_fcnt);

        @(posedge clk);
        if (m_valid[L] && m_wr[L] && !r_eff[L]) m_err = 1'b1;
        if (e_stall && m_scnt < 16'hFFFF) m_scnt++;
        if (flush && m_fcnt < 16'hFFFF) m_fcnt++;
        for (int k = DEPTH - 1; k > 0; k--) begin
            m_valid[k] = m_valid[k-1] && !(flush && (k - 1) < int'(flush_k));
            m_wr[k]    = m_wr[k-1];
            m_dest[k]  = m_dest[k-1];
            m_rdy[k]   = r_eff[k-1];
            m_data[k]  = d_eff[k-1];
        end
        m_valid[0] = in_valid && !e_stall && !flush;
        m_wr[0]    = in_wr_en;
        m_dest[0]  = in_dest;
        m_rdy[0]   = 1'b0;
        m_data[0]  = '0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr_in();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_fwd_en", fwd_en, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_err", err_noresult, 0);
        @(negedge clk);
        rst = 1'b0;

        // Result at stage 0 forwarded next cycle through the same-cycle bypass.
        in_valid = 1; in_wr_en = 1; in_dest = 3;
        step();
        clr_in(); res_we = 4'b0001; res_data[15:0] = 16'h1234; src_addr[2:0] = 3; src_used = 2'b01;
        #1;
        chk("r39_fwd_en", fwd_en[0], 1);
        chk("r39_fwd_data", fwd_data[15:0], 16'h1234);
        chk("r39_stall", stall, 0);
        step();

        // Load-use: one stall cycle, then forward from stage 1.
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 5;
        step();
        clr_in(); in_valid = 1; in_dest = 1; src_addr[2:0] = 5; src_used = 2'b01;
        #1;
        chk("r40_stall", stall, 1);
        step();
        res_we = 4'b0010; res_data[31:16] = 16'hBEEF;
        #1;
        chk("r40_stall_after", stall, 0);
        chk("r40_fwd_data", fwd_data[15:0], 16'hBEEF);
        chk("r40_stall_cnt", stall_cnt, 1);
        step();

        // Two writers of r2: the younger one wins.
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 2;
        step();
        clr_in(); res_we = 4'b0001; res_data[15:0] = 16'h0AAA;
        step();
        clr_in();
        step();
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 2;
        step();
        clr_in(); res_we = 4'b0001; res_data[15:0] = 16'h0002; src_addr[2:0] = 2; src_used = 2'b01;
        #1;
        chk("r41_fwd_data", fwd_data[15:0], 16'h0002);
        step();

        // Partial flush of the two youngest stages.
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 1;
        step();
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 2; res_we = 4'b0001; res_data[15:0] = 16'h00A1;
        step();
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 4; res_we = 4'b0001; res_data[15:0] = 16'h00B2;
        step();
        clr_in(); flush = 1; flush_k = 2; in_valid = 1; in_wr_en = 1; in_dest = 7;
        res_we = 4'b0001; res_data[15:0] = 16'h00C3;
        step();
        clr_in();
        #1;
        chk("r42_wb_valid", wb_valid, 1);
        chk("r42_wb_dest", wb_dest, 1);
        chk("r42_wb_data", wb_data, 16'h00A1);
        chk("r42_flush_cnt", flush_cnt, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r42_no_wb", wb_valid, 0);
            step();
        end

        // Writer never gets a result before reaching the oldest stage.
        chk("r44_err_before", err_noresult, 0);
        clr_in(); in_valid = 1; in_wr_en = 1; in_dest = 6;
        step();
        clr_in();
        for (int i = 0; i < 4; i++) step();
        chk("r44_err_set", err_noresult, 1);
        for (int i = 0; i < 3; i++) step();
        chk("r44_err_sticky", err_noresult, 1);

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_wr_en = 1'($urandom_range(0, 1));
            in_dest  = RA_W'($urandom_range(0, 7));
            res_we   = DEPTH'($urandom);
            res_data = {$urandom, $urandom};
            src_addr = (NSRC*RA_W)'($urandom);
            src_used = NSRC'($urandom);
            flush    = ($urandom_range(0, 9) == 0);
            flush_k  = FK_W'($urandom_range(0, 7));
            step();
        end

        // Fill the pipe with ready writers, then assert reset between edges.
        for (int i = 0; i < DEPTH; i++) begin
            clr_in(); in_valid = 1; in_wr_en = 1; in_dest = RA_W'(i + 1);
            res_we = 4'b0001; res_data[15:0] = 16'(16'h5000 + i);
            step();
        end
        clr_in(); res_we = 4'b0001; res_data[15:0] = 16'h5555;
        #1;
        chk("r43_wb_before", wb_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("r43_wb_valid", wb_valid, 0);
        chk("r43_wb_data", wb_data, 0);
        chk("r43_stall", stall, 0);
        chk("r43_fwd_en", fwd_en, 0);
        chk("r43_stall_cnt", stall_cnt, 0);
        chk("r43_flush_cnt", flush_cnt, 0);
        chk("r43_err", err_noresult, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clr_in();
        for (int i = 0; i < DEPTH + 1; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
